// File: rtl/cdc_pkg.sv
// Shared definitions for the clock-domain-crossing handshake blocks.
// The transmitter FSM and every synchronizer instance use the same state
// encoding and agree on the legal synchronizer depth range.
package cdc_pkg;

  // Synchronizer depth limits. Two flops is the minimum for a useful MTBF.
  // Beyond four flops, extra latency buys nothing at our clock rates.
  localparam int SYNC_STAGES_MIN = 2;
  localparam int SYNC_STAGES_MAX = 4;

  // Transmitter state encoding. The code 2'd3 is unused and decodes as IDLE.
  localparam logic [1:0] ST_IDLE       = 2'd0;
  localparam logic [1:0] ST_WAIT_ACK_H = 2'd1;
  localparam logic [1:0] ST_WAIT_ACK_L = 2'd2;

  typedef enum logic [1:0] {
    IDLE       = ST_IDLE,
    WAIT_ACK_H = ST_WAIT_ACK_H,
    WAIT_ACK_L = ST_WAIT_ACK_L
  } state_e;

  // True for IDLE and for the unused code. A corrupted state register
  // therefore behaves as idle and never holds req_out high.
  function automatic logic is_idle(input state_e s);
    return (s != WAIT_ACK_H) && (s != WAIT_ACK_L);
  endfunction

  // Forces a requested synchronizer depth into the legal range. An
  // out-of-range parameter then still gives a working chain of known depth.
  function automatic int clamp_stages(input int n);
    if (n < SYNC_STAGES_MIN) return SYNC_STAGES_MIN;
    if (n > SYNC_STAGES_MAX) return SYNC_STAGES_MAX;
    return n;
  endfunction

endpackage

// File: rtl/cdc_sync_bit.sv
// N-stage single-bit synchronizer. It brings an asynchronous level into the
// clk_in domain. The receiver side reuses it for its req input.
// Only the last stage may be used by downstream logic. The earlier stages
// can go metastable.
module cdc_sync_bit
  import cdc_pkg::*;
#(
  parameter int STAGES = 2
) (
  input  logic clk_in,
  input  logic rst,
  input  logic i_async,
  output logic o_sync
);

  localparam int L_STAGES = clamp_stages(STAGES);

  logic [L_STAGES-1:0] r_sync;

  // Shift the asynchronous level through the chain; bit 0 samples the input.
  // NOTE: sequential state is written with non-blocking assignments only, so
  // every flop samples the pre-edge value of its neighbour and the chain
  // really is L_STAGES flops deep rather than collapsing into one.
  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      r_sync <= '0;
    end else begin
      r_sync <= {r_sync[L_STAGES-2:0], i_async};
    end
  end

  assign o_sync = r_sync[L_STAGES-1];

endmodule

// File: rtl/cdc_handshake_tx.sv
// Source-domain transmitter of a 4-phase req/ack handshake.
// A word accepted on valid_in/ready_out is registered onto data_out. The
// word is held there while req_out goes high. The destination answers with
// ack_in. req_out drops once the synchronized ack is seen. A new word is
// accepted only after ack has returned to zero.
// All outputs come straight from flops or from a small function of flops.
// No output has a combinational path from ack_in or valid_in.
module cdc_handshake_tx
  import cdc_pkg::*;
#(
  parameter int DATA_W      = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic              clk_in,
  input  logic              rst,
  input  logic [DATA_W-1:0] data_in,
  input  logic              valid_in,
  output logic              ready_out,
  output logic [DATA_W-1:0] data_out,
  output logic              req_out,
  input  logic              ack_in,
  output logic              busy_out
);

  localparam int L_STAGES = clamp_stages(SYNC_STAGES);

  state_e            r_state;
  state_e            w_state_nxt;
  logic              r_req;
  logic              w_req_nxt;
  logic [DATA_W-1:0] r_data;
  logic [DATA_W-1:0] w_data_nxt;
  logic              w_ack_sync;
  logic              w_idle;
  logic              w_accept;

  // ack_in comes from the destination clock domain. Only the synchronized
  // copy may influence any state here.
  cdc_sync_bit #(
    .STAGES (L_STAGES)
  ) u_ack_sync (
    .clk_in  (clk_in),
    .rst     (rst),
    .i_async (ack_in),
    .o_sync  (w_ack_sync)
  );

  assign w_idle = is_idle(r_state);

  // A stale or erroneous ack seen while idle blocks new words. Starting a
  // request before ack has returned low would break the 4-phase pairing.
  assign ready_out = w_idle && !w_ack_sync;
  assign w_accept  = valid_in && ready_out;

  // Next-state, next-request and next-data decisions for the handshake FSM.
  // NOTE: every signal written here receives a default first. Without it, a
  // branch that leaves a signal unassigned would infer a latch.
  always_comb begin
    w_state_nxt = r_state;
    w_req_nxt   = r_req;
    w_data_nxt  = r_data;
    case (r_state)
      WAIT_ACK_H: begin
        // Hold req and the word until the destination acknowledges.
        w_req_nxt = 1'b1;
        if (w_ack_sync) begin
          w_req_nxt   = 1'b0;
          w_state_nxt = WAIT_ACK_L;
        end
      end
      WAIT_ACK_L: begin
        // req is already low. Wait for ack to return to zero, which completes
        // the return-to-zero half of the handshake.
        w_req_nxt = 1'b0;
        if (!w_ack_sync) begin
          w_state_nxt = IDLE;
        end
      end
      default: begin
        // IDLE and the unused code. Normalise the state and keep req low
        // until a word is accepted.
        w_state_nxt = IDLE;
        w_req_nxt   = 1'b0;
        if (w_accept) begin
          w_data_nxt  = data_in;
          w_req_nxt   = 1'b1;
          w_state_nxt = WAIT_ACK_H;
        end
      end
    endcase
  end

  // State, request and data registers. Reset clears req_out asynchronously,
  // so a mid-transfer reset drops the request at once.
  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_req   <= 1'b0;
      r_data  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_req   <= w_req_nxt;
      r_data  <= w_data_nxt;
    end
  end

  assign req_out  = r_req;
  assign data_out = r_data;
  assign busy_out = !w_idle;

endmodule
